// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings and width defaults for the MEM/WB stage.
//   WB_*  : writeback source select encodings (InWbSel)
//   LD_*  : load type encodings (InLoadType); unlisted codes behave as LW
package pipeline_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wbSel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } loadType_e;

  function automatic logic isHalfLoad(input logic [2:0] loadType);
    return (loadType == LD_H) || (loadType == LD_HU);
  endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational load data alignment and extension.
//   MemData        in   raw aligned big-endian word (byte 0 = [31:24])
//   LoadType       in   LD_* encoding
//   ByteOffset     in   address[1:0] of the load
//   LoadData       out  selected and sign/zero-extended value
//   HalfMisaligned out  halfword load at an odd offset
module load_extract
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] MemData,
  input  logic [2:0]        LoadType,
  input  logic [1:0]        ByteOffset,
  output logic [DATA_W-1:0] LoadData,
  output logic              HalfMisaligned
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = MemData[31:24];
    case (ByteOffset)
      2'd0:    byteSel = MemData[31:24];
      2'd1:    byteSel = MemData[23:16];
      2'd2:    byteSel = MemData[15:8];
      default: byteSel = MemData[7:0];
    endcase
    // Odd halfword offsets are flagged as misaligned; the data picked here
    // is never written because the write gets suppressed.
    halfSel = ByteOffset[1] ? MemData[15:0] : MemData[31:16];
  end

  always_comb begin
    LoadData = MemData;
    case (LoadType)
      LD_B:    LoadData = {{(DATA_W-8){byteSel[7]}}, byteSel};
      LD_BU:   LoadData = {{(DATA_W-8){1'b0}}, byteSel};
      LD_H:    LoadData = {{(DATA_W-16){halfSel[15]}}, halfSel};
      LD_HU:   LoadData = {{(DATA_W-16){1'b0}}, halfSel};
      default: LoadData = MemData;
    endcase
  end

  assign HalfMisaligned = isHalfLoad(LoadType) & ByteOffset[0];

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register feeding the register file.
//   Clk, Rst_n        clock, async active-low reset
//   Stall, Flush      hold contents / insert bubble (Flush wins)
//   In*               retiring instruction from the MEM stage
//   WriteRegister, WriteData, RegWrite   register file write port
//   FwdValid, FwdRegister, FwdData       forwarding tap for the hazard unit
//   Misaligned        one-cycle flag for a halfword load at an odd offset
//   RetireCount       count of accepted valid instructions (wraps)
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = pipeline_pkg::DATA_W,
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  InValid,
  input  logic                  InRegWrite,
  input  logic [1:0]            InWbSel,
  input  logic [2:0]            InLoadType,
  input  logic [1:0]            InByteOffset,
  input  logic [REG_ADDR_W-1:0] InWriteRegister,
  input  logic [DATA_W-1:0]     InAluResult,
  input  logic [DATA_W-1:0]     InMemData,
  input  logic [DATA_W-1:0]     InLinkAddr,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0]     WriteData,
  output logic                  RegWrite,
  output logic                  FwdValid,
  output logic [REG_ADDR_W-1:0] FwdRegister,
  output logic [DATA_W-1:0]     FwdData,
  output logic                  Misaligned,
  output logic [31:0]           RetireCount
);

  logic [DATA_W-1:0] loadData;
  logic              halfMisaligned;
  logic              misalignedIn;
  logic              regWriteNext;
  logic [DATA_W-1:0] wbDataNext;

  logic              regWriteQ;
  logic              misalignedQ;
  logic              held;
  logic [31:0]       retireCount;

  load_extract #(.DATA_W(DATA_W)) uLoadExtract (
    .MemData        (InMemData),
    .LoadType       (InLoadType),
    .ByteOffset     (InByteOffset),
    .LoadData       (loadData),
    .HalfMisaligned (halfMisaligned)
  );

  always_comb begin
    misalignedIn = (InWbSel == WB_LOAD) & halfMisaligned;
    regWriteNext = InValid & InRegWrite & (InWriteRegister != '0) & ~misalignedIn;
    case (InWbSel)
      WB_LOAD: wbDataNext = loadData;
      WB_LINK: wbDataNext = InLinkAddr;
      default: wbDataNext = InAluResult;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      WriteRegister <= '0;
      WriteData     <= '0;
      regWriteQ     <= 1'b0;
      misalignedQ   <= 1'b0;
      held          <= 1'b0;
      retireCount   <= '0;
    end else if (Flush) begin
      WriteRegister <= '0;
      WriteData     <= '0;
      regWriteQ     <= 1'b0;
      misalignedQ   <= 1'b0;
      held          <= 1'b0;
    end else if (Stall) begin
      held          <= 1'b1;
    end else begin
      WriteRegister <= InWriteRegister;
      WriteData     <= wbDataNext;
      regWriteQ     <= regWriteNext;
      misalignedQ   <= InValid & misalignedIn;
      held          <= 1'b0;
      if (InValid) retireCount <= retireCount + 32'd1;
    end
  end

  // regWriteQ keeps the unmasked qualification through a stall so the value
  // stays forwardable; held masks the one-shot outputs after the first cycle.
  assign RegWrite    = regWriteQ & ~held;
  assign Misaligned  = misalignedQ & ~held;
  assign FwdValid    = regWriteQ;
  assign FwdRegister = WriteRegister;
  assign FwdData     = WriteData;
  assign RetireCount = retireCount;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic        InRegWrite = 1'b0;
  logic [1:0]  InWbSel = '0;
  logic [2:0]  InLoadType = '0;
  logic [1:0]  InByteOffset = '0;
  logic [4:0]  InWriteRegister = '0;
  logic [31:0] InAluResult = '0;
  logic [31:0] InMemData = '0;
  logic [31:0] InLinkAddr = '0;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic        FwdValid;
  logic [4:0]  FwdRegister;
  logic [31:0] FwdData;
  logic        Misaligned;
  logic [31:0] RetireCount;

  int nCompared = 0;
  int nMismatch = 0;

  // reference model state: what the register file / tap should see
  logic [4:0]  mWr;
  logic [31:0] mWd;
  logic        mRw, mFv, mMis;
  logic [31:0] mCnt;

  mem_wb_stage dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
    .InValid(InValid), .InRegWrite(InRegWrite), .InWbSel(InWbSel),
    .InLoadType(InLoadType), .InByteOffset(InByteOffset),
    .InWriteRegister(InWriteRegister), .InAluResult(InAluResult),
    .InMemData(InMemData), .InLinkAddr(InLinkAddr),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .FwdValid(FwdValid), .FwdRegister(FwdRegister), .FwdData(FwdData),
    .Misaligned(Misaligned), .RetireCount(RetireCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [31:0] mem, input int lt, input int off);
    logic [31:0] b, h;
    b = (mem >> (8 * (3 - off))) & 32'hFF;
    h = (mem >> (16 * (1 - off / 2))) & 32'hFFFF;
    case (lt)
      1: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      2: return b;
      3: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      4: return h;
      default: return mem;
    endcase
  endfunction

  function automatic void modelReset();
    mWr = 0; mWd = 0; mRw = 0; mFv = 0; mMis = 0; mCnt = 0;
  endfunction

  // advance the model by one clock edge using the currently driven inputs
  function automatic void modelEdge();
    bit misIn, qual;
    if (Flush) begin
      mWr = 0; mWd = 0; mRw = 0; mFv = 0; mMis = 0;
    end else if (Stall) begin
      mRw = 0; mMis = 0;
    end else begin
      misIn = (InWbSel == 1) && (InLoadType == 3 || InLoadType == 4) && (InByteOffset % 2 == 1);
      qual  = InValid && InRegWrite && (InWriteRegister != 0) && !misIn;
      mWr = InWriteRegister;
      mWd = (InWbSel == 1) ? refLoad(InMemData, int'(InLoadType), int'(InByteOffset))
          : (InWbSel == 2) ? InLinkAddr : InAluResult;
      mRw = qual; mFv = qual;
      mMis = InValid && misIn;
      if (InValid) mCnt = mCnt + 1;
    end
  endfunction

  task automatic checkAll(input string tag);
    check({tag, ".WriteRegister"}, 32'(WriteRegister), 32'(mWr));
    check({tag, ".WriteData"},     WriteData,          mWd);
    check({tag, ".RegWrite"},      32'(RegWrite),      32'(mRw));
    check({tag, ".FwdValid"},      32'(FwdValid),      32'(mFv));
    check({tag, ".FwdRegister"},   32'(FwdRegister),   32'(mWr));
    check({tag, ".FwdData"},       FwdData,            mWd);
    check({tag, ".Misaligned"},    32'(Misaligned),    32'(mMis));
    check({tag, ".RetireCount"},   RetireCount,        mCnt);
  endtask

  task automatic step(input string tag);
    modelEdge();
    @(posedge Clk);
    #1;
    checkAll(tag);
  endtask

  task automatic drive(input bit v, input bit rw, input logic [1:0] sel, input logic [2:0] lt,
                       input logic [1:0] off, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] link);
    InValid = v; InRegWrite = rw; InWbSel = sel; InLoadType = lt; InByteOffset = off;
    InWriteRegister = rd; InAluResult = alu; InMemData = mem; InLinkAddr = link;
  endtask

  initial begin
    modelReset();
    #12;
    checkAll("reset");
    @(negedge Clk);
    Rst_n = 1'b1;

    // LB sign-extended
    drive(1, 1, 2'b01, 3'b001, 2'd1, 5'd5, 32'h0, 32'h1280FF34, 32'h0);
    step("lb");
    check("lb_const_data", WriteData, 32'hFFFFFF80);
    check("lb_const_rw", 32'(RegWrite), 32'd1);
    check("lb_const_cnt", RetireCount, 32'd1);

    // LHU at offset 2, then LH at offset 3 (misaligned)
    drive(1, 1, 2'b01, 3'b100, 2'd2, 5'd6, 32'h0, 32'hAAAA8001, 32'h0);
    step("lhu");
    check("lhu_const_data", WriteData, 32'h00008001);
    drive(1, 1, 2'b01, 3'b011, 2'd3, 5'd6, 32'h0, 32'hAAAA8001, 32'h0);
    step("lh_mis");
    check("mis_const_flag", 32'(Misaligned), 32'd1);
    check("mis_const_rw", 32'(RegWrite), 32'd0);
    check("mis_const_cnt", RetireCount, 32'd3);
    InValid = 0;
    step("mis_clear");

    // x0 destination
    drive(1, 1, 2'b00, 3'b000, 2'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    step("x0");
    check("x0_const_fv", 32'(FwdValid), 32'd0);

    // stall holds a single write
    drive(1, 1, 2'b00, 3'b000, 2'd0, 5'd7, 32'h00000042, 32'h0, 32'h0);
    step("stall_ld");
    drive(1, 1, 2'b00, 3'b000, 2'd0, 5'd9, 32'h11111111, 32'h0, 32'h0);
    Stall = 1;
    for (int i = 0; i < 3; i++) step("stall");
    check("stall_const_data", WriteData, 32'h00000042);
    check("stall_const_fv", 32'(FwdValid), 32'd1);
    check("stall_const_rw", 32'(RegWrite), 32'd0);

    // flush during stall, then JAL
    Flush = 1;
    step("flush");
    Flush = 0; Stall = 0;
    drive(1, 1, 2'b10, 3'b000, 2'd0, 5'd31, 32'h0, 32'h0, 32'h00400010);
    step("jal");
    check("jal_const_data", WriteData, 32'h00400010);

    // async reset between edges
    #3;
    Rst_n = 0;
    #1;
    modelReset();
    checkAll("async_rst");
    @(negedge Clk);
    Rst_n = 1;
    drive(1, 1, 2'b00, 3'b000, 2'd0, 5'd3, 32'h0BADF00D, 32'h0, 32'h0);
    step("post_rst");

    // counter wrap
    @(negedge Clk);
    force dut.retireCount = 32'hFFFFFFFF;
    #1;
    release dut.retireCount;
    mCnt = 32'hFFFFFFFF;
    step("wrap");
    check("wrap_const_cnt", RetireCount, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      Stall = ($urandom_range(3) == 0);
      Flush = ($urandom_range(9) == 0);
      drive($urandom_range(3) != 0, $urandom_range(3) != 0, 2'($urandom_range(3)),
            3'($urandom_range(7)), 2'($urandom_range(3)),
            ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)),
            $urandom, $urandom, $urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
